// File: rtl/cfu_arbiter_if.sv
// Bundle of requester-side and CFU-side handshake signals around the CFU arbiter.
// slave = arbiter view, master = environment (requesters + CFU) view.
interface cfu_arbiter_if #(
  parameter int NUM_REQ         = 2,
  parameter int ID_W            = 4,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [NUM_REQ-1:0]        s_req_valid;
  logic [NUM_REQ-1:0]        s_req_ready;
  logic [NUM_REQ*ID_W-1:0]   s_req_id;
  logic [NUM_REQ*DATA_W-1:0] s_req_data0;
  logic [NUM_REQ*DATA_W-1:0] s_req_data1;
  logic [NUM_REQ-1:0]        s_resp_valid;
  logic [NUM_REQ-1:0]        s_resp_ready;
  logic [ID_W-1:0]           s_resp_id;
  logic                      s_resp_status;
  logic [DATA_W-1:0]         s_resp_data;

  logic                      m_req_valid;
  logic                      m_req_ready;
  logic [ID_W-1:0]           m_req_id;
  logic [DATA_W-1:0]         m_req_data0;
  logic [DATA_W-1:0]         m_req_data1;
  logic                      m_resp_valid;
  logic                      m_resp_ready;
  logic [ID_W-1:0]           m_resp_id;
  logic                      m_resp_status;
  logic [DATA_W-1:0]         m_resp_data;

  logic [CW-1:0]             outstanding;

  modport slave (
    input  s_req_valid, s_req_id, s_req_data0, s_req_data1, s_resp_ready,
           m_req_ready, m_resp_valid, m_resp_id, m_resp_status, m_resp_data,
    output s_req_ready, s_resp_valid, s_resp_id, s_resp_status, s_resp_data,
           m_req_valid, m_req_id, m_req_data0, m_req_data1, m_resp_ready, outstanding
  );

  modport master (
    output s_req_valid, s_req_id, s_req_data0, s_req_data1, s_resp_ready,
           m_req_ready, m_resp_valid, m_resp_id, m_resp_status, m_resp_data,
    input  s_req_ready, s_resp_valid, s_resp_id, s_resp_status, s_resp_data,
           m_req_valid, m_req_id, m_req_data0, m_req_data1, m_resp_ready, outstanding
  );
endinterface

// File: rtl/cfu_arbiter.sv
// Round-robin arbiter sharing one in-order CFU between NUM_REQ requesters;
// a tag FIFO of grant indices routes each response back to its requester.
module cfu_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ID_W            = 4,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic           clk,
  input logic           rst_n,
  cfu_arbiter_if.slave  bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  logic [GW-1:0] last_q, lock_idx_q, rr_idx, grant, head;
  logic          lock_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] tag_q [MAX_OUTSTANDING];
  logic          full, empty, push, pop;

  // Search starts one past the last accepted requester
  always_comb begin
    logic          found;
    logic [GW-1:0] idx;
    rr_idx = last_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(last_q) + k) % NUM_REQ);
      if (!found && bus.s_req_valid[idx]) begin
        rr_idx = idx;
        found  = 1'b1;
      end
    end
  end

  assign grant = lock_q ? lock_idx_q : rr_idx;
  assign full  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);
  assign head  = tag_q[rd_q];

  assign bus.m_req_valid = rst_n & bus.s_req_valid[grant] & ~full;
  assign bus.m_req_id    = bus.s_req_id[int'(grant)*ID_W +: ID_W];
  assign bus.m_req_data0 = bus.s_req_data0[int'(grant)*DATA_W +: DATA_W];
  assign bus.m_req_data1 = bus.s_req_data1[int'(grant)*DATA_W +: DATA_W];
  assign bus.m_resp_ready = rst_n & bus.s_resp_ready[head] & ~empty;

  assign bus.s_resp_id     = bus.m_resp_id;
  assign bus.s_resp_status = bus.m_resp_status;
  assign bus.s_resp_data   = bus.m_resp_data;

  always_comb begin
    bus.s_req_ready         = '0;
    bus.s_req_ready[grant]  = bus.m_req_valid & bus.m_req_ready;
    bus.s_resp_valid        = '0;
    bus.s_resp_valid[head]  = rst_n & bus.m_resp_valid & ~empty;
  end

  assign push  = bus.m_req_valid & bus.m_req_ready;
  assign pop   = bus.m_resp_valid & bus.m_resp_ready;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  assign bus.outstanding = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q     <= GW'(NUM_REQ - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      // Hold the grant while a request is stalled by the CFU
      lock_q     <= bus.m_req_valid & ~bus.m_req_ready;
      lock_idx_q <= grant;
      cnt_q      <= cnt_d;
      if (push) begin
        last_q <= grant;
        wr_q   <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) tag_q[wr_q] <= grant;
  end

  a_resp_while_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.m_resp_valid && empty));
endmodule

// File: tb/tb_cfu_arbiter.sv
// Directed bench for cfu_arbiter: alternation, grant lock, full FIFO,
// response backpressure, mid-transaction reset, single-requester streaming.
module tb_cfu_arbiter;
  localparam int NUM_REQ = 2, ID_W = 4, DATA_W = 32, MAX_OUT = 4;
  localparam logic [ID_W-1:0]   ID0  = 4'h3, ID1 = 4'hA;
  localparam logic [DATA_W-1:0] R0_A = 32'hA0A0_0001, R0_B = 32'hB0B0_0001;
  localparam logic [DATA_W-1:0] R1_A = 32'hA1A1_0002, R1_B = 32'hB1B1_0002;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cfu_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W),
                   .MAX_OUTSTANDING(MAX_OUT)) bus ();
  cfu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W),
                .MAX_OUTSTANDING(MAX_OUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.s_req_valid   = 2'b11;
    bus.s_req_id      = {ID1, ID0};
    bus.s_req_data0   = {R1_A, R0_A};
    bus.s_req_data1   = {R1_B, R0_B};
    bus.s_resp_ready  = 2'b11;
    bus.m_req_ready   = 1'b1;
    bus.m_resp_valid  = 1'b0;
    bus.m_resp_id     = '0;
    bus.m_resp_status = 1'b0;
    bus.m_resp_data   = '0;
    step(); step();
    chk("rst_outstanding", bus.outstanding, 0);
    chk("rst_m_req_valid", bus.m_req_valid, 0);
    chk("rst_s_req_ready", bus.s_req_ready, 0);
    chk("rst_m_resp_ready", bus.m_resp_ready, 0);
    chk("rst_s_resp_valid", bus.s_resp_valid, 0);

    bus.s_req_valid = 2'b00;
    rst_n = 1'b1;
    step();

    // both requesters valid, CFU answers the previous request every cycle
    bus.s_req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      bus.m_resp_valid = (c > 0);
      bus.m_resp_id    = (c % 2 == 1) ? ID0 : ID1;
      #1;
      chk("alt_req_id", bus.m_req_id, (c % 2 == 0) ? ID0 : ID1);
      chk("alt_req_data1", bus.m_req_data1, (c % 2 == 0) ? R0_B : R1_B);
      chk("alt_s_req_ready", bus.s_req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      chk("alt_s_resp_valid", bus.s_resp_valid, (c == 0) ? 2'b00 : (c % 2 == 1) ? 2'b01 : 2'b10);
      if (c > 0) chk("alt_s_resp_id", bus.s_resp_id, (c % 2 == 1) ? ID0 : ID1);
      step();
    end
    bus.s_req_valid  = 2'b00;
    bus.m_resp_valid = 1'b1;
    bus.m_resp_id    = ID1;
    #1;
    chk("alt_last_resp_valid", bus.s_resp_valid, 2'b10);
    chk("alt_last_m_resp_ready", bus.m_resp_ready, 1);
    step();
    bus.m_resp_valid = 1'b0;
    #1;
    chk("alt_drained", bus.outstanding, 0);

    // req1 stalled by CFU; req0 arrives mid-stall but must not steal the grant
    bus.s_req_valid = 2'b10;
    bus.m_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) bus.s_req_valid = 2'b11;
      #1;
      chk("lock_m_req_valid", bus.m_req_valid, 1);
      chk("lock_req_id", bus.m_req_id, ID1);
      chk("lock_req_data0", bus.m_req_data0, R1_A);
      chk("lock_s_req_ready", bus.s_req_ready, 0);
      step();
    end
    bus.m_req_ready = 1'b1;
    #1;
    chk("lock_accept_id", bus.m_req_id, ID1);
    chk("lock_accept_ready", bus.s_req_ready, 2'b10);
    step();
    chk("lock_next_id", bus.m_req_id, ID0);
    chk("lock_next_ready", bus.s_req_ready, 2'b01);
    step();
    bus.s_req_valid  = 2'b00;
    bus.m_resp_valid = 1'b1;
    #1;
    chk("lock_resp0_route", bus.s_resp_valid, 2'b10);
    step();
    chk("lock_resp1_route", bus.s_resp_valid, 2'b01);
    step();
    bus.m_resp_valid = 1'b0;
    #1;
    chk("lock_drained", bus.outstanding, 0);

    // fill the tag FIFO with a silent CFU
    bus.s_req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("fill_m_req_valid", bus.m_req_valid, 1);
      chk("fill_req_id", bus.m_req_id, (c % 2 == 0) ? ID1 : ID0);
      step();
    end
    chk("full_outstanding", bus.outstanding, 4);
    chk("full_m_req_valid", bus.m_req_valid, 0);
    chk("full_s_req_ready", bus.s_req_ready, 0);
    bus.m_resp_valid = 1'b1;
    #1;
    chk("full_pop_m_resp_ready", bus.m_resp_ready, 1);
    chk("full_pop_no_issue", bus.m_req_valid, 0);
    chk("full_pop_route", bus.s_resp_valid, 2'b10);
    step();
    bus.m_resp_valid = 1'b0;
    #1;
    chk("after_pop_outstanding", bus.outstanding, 3);
    chk("after_pop_issue", bus.m_req_valid, 1);
    chk("after_pop_req_id", bus.m_req_id, ID1);
    step();
    bus.s_req_valid = 2'b00;

    // head requester (0) back-pressures the response
    bus.s_resp_ready  = 2'b00;
    bus.m_resp_valid  = 1'b1;
    bus.m_resp_status = 1'b1;
    bus.m_resp_data   = 32'hDEAD_BEEF;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bp_m_resp_ready", bus.m_resp_ready, 0);
      chk("bp_s_resp_valid", bus.s_resp_valid, 2'b01);
      chk("bp_s_resp_data", bus.s_resp_data, 32'hDEAD_BEEF);
      chk("bp_s_resp_status", bus.s_resp_status, 1);
      step();
    end
    chk("bp_outstanding_held", bus.outstanding, 4);
    bus.s_resp_ready = 2'b01;
    #1;
    chk("bp_release_ready", bus.m_resp_ready, 1);
    step();
    bus.m_resp_valid = 1'b0;
    bus.s_resp_ready = 2'b11;
    #1;
    chk("bp_outstanding_dec", bus.outstanding, 3);

    // reset with three tags outstanding and a response on the wire
    rst_n            = 1'b0;
    bus.s_req_valid  = 2'b11;
    bus.m_resp_valid = 1'b1;
    step();
    chk("mrst_outstanding", bus.outstanding, 0);
    chk("mrst_m_req_valid", bus.m_req_valid, 0);
    chk("mrst_m_resp_ready", bus.m_resp_ready, 0);
    chk("mrst_s_resp_valid", bus.s_resp_valid, 0);
    chk("mrst_s_req_ready", bus.s_req_ready, 0);
    bus.m_resp_valid = 1'b0;
    bus.s_req_valid  = 2'b00;
    rst_n = 1'b1;
    step();
    chk("mrst_empty_no_resp_ready", bus.m_resp_ready, 0);
    chk("mrst_outstanding_after", bus.outstanding, 0);

    // only requester 1 streams five requests back to back
    bus.s_req_valid = 2'b10;
    bus.m_resp_id   = ID1;
    for (int c = 0; c < 5; c++) begin
      bus.m_resp_valid = (c > 0);
      #1;
      chk("solo_m_req_valid", bus.m_req_valid, 1);
      chk("solo_s_req_ready", bus.s_req_ready, 2'b10);
      chk("solo_s_resp_valid", bus.s_resp_valid, (c > 0) ? 2'b10 : 2'b00);
      step();
    end
    bus.s_req_valid  = 2'b00;
    bus.m_resp_valid = 1'b1;
    #1;
    chk("solo_last_resp", bus.s_resp_valid, 2'b10);
    step();
    bus.m_resp_valid = 1'b0;
    #1;
    chk("solo_drained", bus.outstanding, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
